fft_pitch_tracker: RTL



---
 rtl/pitch_pkg.sv | 25 ++
 rtl/fft_pitch_tracker_if.sv | 25 ++
 rtl/fft_bin_peak_search.sv | 93 +++++++++
 rtl/fft_pitch_tracker.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/pitch_pkg.sv
// Shared types for the FFT pitch tracker: tracker states, result record and the
// bin-index width helper. Result record fields are sized for the default build.
package pitch_pkg;

  function automatic int kw(input int n);
    return $clog2(n);
  endfunction

  localparam int PITCH_W        = 33;
  localparam int PITCH_NSAMPLES = 1024;
  localparam int PITCH_KW       = kw(PITCH_NSAMPLES);

  typedef enum logic [1:0] {
    SILENT,
    CANDIDATE,
    LOCKED
  } tracker_state_t;

  typedef struct packed {
    logic [PITCH_KW-1:0] k;
    logic [PITCH_W-1:0]  mag;
    logic                voiced;
  } pitch_result_t;

endpackage

// File: rtl/fft_pitch_tracker_if.sv
// Bin-magnitude input stream plus the pitch-result valid/ready output of the tracker.
interface fft_pitch_tracker_if import pitch_pkg::*; #(
  parameter int W  = PITCH_W,
  parameter int KW = PITCH_KW
);
  logic [W-1:0]  mag;
  logic          mag_valid;
  logic [W-1:0]  threshold;
  logic [KW-1:0] pitch_k;
  logic [W-1:0]  pitch_mag;
  logic          pitch_voiced;
  logic          pitch_valid;
  logic          pitch_ready;
  logic          overrun;

  modport master (
    output mag, mag_valid, threshold, pitch_ready,
    input  pitch_k, pitch_mag, pitch_voiced, pitch_valid, overrun
  );

  modport slave (
    input  mag, mag_valid, threshold, pitch_ready,
    output pitch_k, pitch_mag, pitch_voiced, pitch_valid, overrun
  );
endinterface

// File: rtl/fft_bin_peak_search.sv
// Bin counter, windowed argmax and frame-end snapshot with voicing decision.
// NEIGHBOUR_SUM_EN switches the search metric to a 3-bin sum around the centre.
module fft_bin_peak_search import pitch_pkg::*; #(
  parameter int W        = PITCH_W,
  parameter int NSamples = PITCH_NSAMPLES,
  parameter int K_MIN    = 1,
  parameter int K_MAX    = 511,
  parameter int KW       = kw(NSamples)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [W-1:0]  mag,
  input  logic          mag_valid,
  input  logic [W-1:0]  threshold,
  output logic          frame_done,
  output logic [KW-1:0] eval_k,
  output logic [W-1:0]  eval_mag,
  output logic          eval_voiced
);
`ifdef NEIGHBOUR_SUM_EN
  localparam int MW = W + 2;
`else
  localparam int MW = W;
`endif

  logic [KW-1:0] cnt, best_k, cand_k, nxt_k;
  logic [MW-1:0] best_metric, cand_metric, nxt_metric;
  logic [W-1:0]  best_raw, cand_raw, nxt_raw;
  logic          frame_end, in_win, take;

`ifdef NEIGHBOUR_SUM_EN
  logic [W-1:0] d1, d2;

  // Centre k = previous bin; it is scored once bin k+1 is on the input.
  always_ff @(posedge clk) begin
    if (reset) begin
      d1 <= '0;
      d2 <= '0;
    end else if (mag_valid) begin
      d1 <= mag;
      d2 <= d1;
    end
  end

  assign cand_k      = cnt - KW'(1);
  assign cand_metric = MW'(d2) + MW'(d1) + MW'(mag);
  assign cand_raw    = d1;
`else
  assign cand_k      = cnt;
  assign cand_metric = mag;
  assign cand_raw    = mag;
`endif

  assign frame_end = mag_valid && (cnt == KW'(NSamples - 1));
  assign in_win    = (cand_k >= KW'(K_MIN)) && (cand_k <= KW'(K_MAX));
  assign take      = mag_valid && in_win && (cand_metric > best_metric);

  assign nxt_k      = take ? cand_k      : best_k;
  assign nxt_metric = take ? cand_metric : best_metric;
  assign nxt_raw    = take ? cand_raw    : best_raw;

  // The frame-end beat may itself update the best, so the snapshot takes nxt_*.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= '0;
      best_k      <= '0;
      best_metric <= '0;
      best_raw    <= '0;
      eval_k      <= '0;
      eval_mag    <= '0;
      eval_voiced <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= frame_end;
      if (mag_valid) begin
        cnt <= frame_end ? '0 : cnt + KW'(1);
        if (frame_end) begin
          eval_k      <= nxt_k;
          eval_mag    <= nxt_raw;
          eval_voiced <= (nxt_metric >= MW'(threshold)) && (nxt_metric != '0);
          best_k      <= '0;
          best_metric <= '0;
          best_raw    <= '0;
        end else begin
          best_k      <= nxt_k;
          best_metric <= nxt_metric;
          best_raw    <= nxt_raw;
        end
      end
    end
  end

endmodule

// File: rtl/fft_pitch_tracker.sv
// Pitch tracker top: frame argmax (fft_bin_peak_search), lock/silence debounce FSM and
// valid/ready result register with sticky overrun. NEIGHBOUR_SUM_EN selects 3-bin metric.
//   state     | meaning
//   SILENT    | no candidate, nothing locked since last silence report
//   CANDIDATE | counting consecutive matching voiced frames
//   LOCKED    | reported pitch stands; matching frames keep it
module fft_pitch_tracker import pitch_pkg::*; #(
  parameter int W              = PITCH_W,
  parameter int NSamples       = PITCH_NSAMPLES,
  parameter int K_MIN          = 1,
  parameter int K_MAX          = 511,
  parameter int TOL            = 1,
  parameter int STABLE_FRAMES  = 3,
  parameter int SILENCE_FRAMES = 4
) (
  input logic               clk,
  input logic               reset,
  fft_pitch_tracker_if.slave bus
);
  localparam int KW = kw(NSamples);
  localparam int CW = $clog2(STABLE_FRAMES + 1);
  localparam int SW = $clog2(SILENCE_FRAMES + 1);

  logic          frame_done, eval_voiced;
  logic [KW-1:0] eval_k;
  logic [W-1:0]  eval_mag;

  fft_bin_peak_search #(
    .W(W), .NSamples(NSamples), .K_MIN(K_MIN), .K_MAX(K_MAX), .KW(KW)
  ) u_search (
    .clk(clk), .reset(reset), .mag(bus.mag), .mag_valid(bus.mag_valid),
    .threshold(bus.threshold), .frame_done(frame_done), .eval_k(eval_k),
    .eval_mag(eval_mag), .eval_voiced(eval_voiced)
  );

  tracker_state_t state, state_nxt;
  logic [KW-1:0]  cand_k, cand_k_nxt, lock_k, lock_k_nxt;
  logic [CW-1:0]  cand_cnt, cand_cnt_nxt;
  logic [SW-1:0]  sil_cnt, sil_cnt_nxt;
  logic           has_lock, has_lock_nxt, lock_now, drop_now;
  logic           emit, valid, overrun;
  pitch_result_t  res, emit_res;

  function automatic logic near(input logic [KW-1:0] a, input logic [KW-1:0] b);
    logic signed [KW:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    if (d < 0) d = -d;
    return d <= $signed((KW+1)'(TOL));
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= SILENT;
      cand_k   <= '0;
      cand_cnt <= '0;
      lock_k   <= '0;
      sil_cnt  <= '0;
      has_lock <= 1'b0;
      res      <= '0;
      valid    <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cand_k   <= cand_k_nxt;
      cand_cnt <= cand_cnt_nxt;
      lock_k   <= lock_k_nxt;
      sil_cnt  <= sil_cnt_nxt;
      has_lock <= has_lock_nxt;
      if (emit) begin
        res   <= emit_res;
        valid <= 1'b1;
        if (valid && !bus.pitch_ready) overrun <= 1'b1;
      end else if (valid && bus.pitch_ready) begin
        valid <= 1'b0;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    cand_k_nxt   = cand_k;
    cand_cnt_nxt = cand_cnt;
    lock_k_nxt   = lock_k;
    sil_cnt_nxt  = sil_cnt;
    has_lock_nxt = has_lock;
    lock_now     = 1'b0;
    drop_now     = 1'b0;
    if (frame_done) begin
      if (eval_voiced) begin
        sil_cnt_nxt = '0;
        unique case (state)
          CANDIDATE: begin
            if (near(eval_k, cand_k)) begin
              cand_cnt_nxt = cand_cnt + CW'(1);
            end else begin
              cand_k_nxt   = eval_k;
              cand_cnt_nxt = CW'(1);
            end
          end
          LOCKED: begin
            if (!near(eval_k, lock_k)) begin
              state_nxt    = CANDIDATE;
              cand_k_nxt   = eval_k;
              cand_cnt_nxt = CW'(1);
            end
          end
          default: begin
            state_nxt    = CANDIDATE;
            cand_k_nxt   = eval_k;
            cand_cnt_nxt = CW'(1);
          end
        endcase
        if (state_nxt == CANDIDATE && cand_cnt_nxt >= CW'(STABLE_FRAMES)) begin
          state_nxt    = LOCKED;
          lock_k_nxt   = eval_k;
          has_lock_nxt = 1'b1;
          lock_now     = 1'b1;
        end
      end else begin
        // Saturate so long silences cannot wrap back into a spurious drop.
        if (sil_cnt != SW'(SILENCE_FRAMES)) sil_cnt_nxt = sil_cnt + SW'(1);
        if (has_lock && sil_cnt_nxt == SW'(SILENCE_FRAMES)) begin
          drop_now     = 1'b1;
          has_lock_nxt = 1'b0;
          state_nxt    = SILENT;
        end else if (state == CANDIDATE) begin
          state_nxt = has_lock ? LOCKED : SILENT;
        end
      end
    end
  end

  always_comb begin
    emit     = lock_now | drop_now;
    emit_res = '0;
    if (lock_now) begin
      emit_res.k      = eval_k;
      emit_res.mag    = eval_mag;
      emit_res.voiced = 1'b1;
    end
  end

  assign bus.pitch_k      = res.k;
  assign bus.pitch_mag    = res.mag;
  assign bus.pitch_voiced = res.voiced;
  assign bus.pitch_valid  = valid;
  assign bus.overrun      = overrun;

endmodule
